// File: rtl/pla_stim_pkg.sv
// Shared types and constants for the PLA stimulus generator.
package pla_stim_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 17;

  // Taps at bits 15,13,12,10: x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

endpackage

// File: rtl/pla_stim_next.sv
// Next-vector function: increment (mode 0) or one Fibonacci LFSR step (mode 1).
module pla_stim_next
  import pla_stim_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         mode_i,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] x_next_o
);

  logic fb;

  assign fb       = ^(x_i & W'(LFSR_TAPS));
  assign x_next_o = mode_i ? {x_i[W-2:0], fb} : x_i + W'(1);

endmodule

// File: rtl/pla_stim_gen.sv
// Emits num_vec vectors (up-count or LFSR) over valid/ready, then a one-cycle done.
// Define PLA_STIM_ABORT_EN to add an abort input that cancels a running sequence.
module pla_stim_gen
  import pla_stim_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [W-1:0]     seed,
  input  logic [CNT_W-1:0] num_vec,
`ifdef PLA_STIM_ABORT_EN
  input  logic             abort,
`endif
  output logic [W-1:0]     x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  state_t           state_q;
  logic [W-1:0]     x_q;
  logic [W-1:0]     x_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  pla_stim_next #(.W(W)) u_next (
    .mode_i   (mode_q),
    .x_i      (x_q),
    .x_next_o (x_d)
  );

  // All outputs are registered, so out_ready never reaches out_valid or x combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            x_q    <= (mode && seed == '0) ? W'(LFSR_ZERO_SUB) : seed;
            cnt_q  <= num_vec;
            busy_q <= 1'b1;
            if (num_vec == '0) begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end else begin
              state_q     <= RUN;
              out_valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
`ifdef PLA_STIM_ABORT_EN
          if (abort) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end else
`endif
          if (out_ready) begin
            x_q   <= x_d;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q     <= FIN;
              out_valid_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign x         = x_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/pla_stim_gen.md
PLA_STIM_GEN -- requirements
Module: pla_stim_gen

Interface
REQ-001 The module SHALL have parameter W, default 16: width of the input vector driven into the downstream PLA-derived combinational function (x0..x15).
REQ-002 The module SHALL have parameter CNT_W, default 17: width of the vector-count input, so that 2^16 vectors can be requested.
REQ-003 The module SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit: one-cycle request to begin a sequence.
REQ-006 The module SHALL have port mode, input, 1 bit: 0 = exhaustive up-count, 1 = LFSR.
REQ-007 The module SHALL have port seed, input, W bits: first vector of the sequence.
REQ-008 The module SHALL have port num_vec, input, CNT_W bits: number of vectors to emit.
REQ-009 The module SHALL have port x, output, W bits: current vector; bit i drives downstream xi.
REQ-010 The module SHALL have port out_valid, output, 1 bit: x holds a valid vector.
REQ-011 The module SHALL have port out_ready, input, 1 bit: downstream accepts x.
REQ-012 The module SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-013 The module SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a sequence.

Function
REQ-014 The module SHALL implement the FSM states IDLE, RUN and FIN.
REQ-015 In IDLE with start=1, the module SHALL sample mode, seed and num_vec.
REQ-016 On that IDLE start, if num_vec=0 the module SHALL go to FIN; otherwise it SHALL go to RUN.
REQ-017 In RUN, out_valid SHALL be 1, and the first vector SHALL appear the cycle after start (latency 1).
REQ-018 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1.
REQ-019 While out_valid=1 and out_ready=0, x SHALL hold stable.
REQ-020 After each transfer in mode 0, the module SHALL set x to x+1 modulo 2^W, wrapping 0xFFFF to 0x0000.
REQ-021 After each transfer in mode 1, the module SHALL set x to {x[W-2:0], x[15]^x[13]^x[12]^x[10]} (polynomial x^16+x^14+x^13+x^11+1).
REQ-022 In mode 1 with seed=0, the module SHALL load 0x0001 instead (no LFSR lockup); mode 0 SHALL accept seed 0.
REQ-023 On the transfer that completes the num_vec-th vector, the FSM SHALL go to FIN and out_valid SHALL drop the next cycle.
REQ-024 FIN SHALL last exactly one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-025 busy SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-026 start SHALL be ignored in RUN and FIN.
REQ-027 start in IDLE on the same cycle as the FIN-to-IDLE return SHALL be ignored; a new start SHALL be accepted from IDLE only.
REQ-028 mode, seed and num_vec changes after sampling SHALL have no effect until the next accepted start.
REQ-029 The module SHALL contain no combinational path from out_ready to out_valid or to x.

Reset
REQ-030 The module SHALL use asynchronous active-low reset rst_n.
REQ-031 While rst_n=0, the FSM SHALL be IDLE and out_valid, busy and done SHALL be 0.
REQ-032 While rst_n=0, x SHALL be 0 and the internal counter SHALL be 0.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence with no done pulse.
REQ-034 After reset deassertion, the first accepted start SHALL behave identically to start after power-up.

Configuration
REQ-035 The module SHALL provide macro PLA_STIM_ABORT_EN.
REQ-036 With PLA_STIM_ABORT_EN defined, the module SHALL add a 1-bit input port abort.
REQ-037 With PLA_STIM_ABORT_EN defined, abort=1 in RUN SHALL move the FSM to IDLE next cycle with out_valid=0 and no done pulse.
REQ-038 With PLA_STIM_ABORT_EN defined, abort in IDLE or FIN SHALL be ignored, and abort SHALL take priority over a simultaneous final transfer.
REQ-039 Without PLA_STIM_ABORT_EN, the abort port and its logic SHALL be absent, and the behaviour SHALL otherwise be identical.

Structure
REQ-040 A shared package pla_stim_pkg SHALL hold the FSM state enum (IDLE, RUN, FIN).
REQ-041 pla_stim_pkg SHALL hold constant LFSR_TAPS = 16'hB400.
REQ-042 pla_stim_pkg SHALL hold constant LFSR_ZERO_SUB = 16'h0001.
REQ-043 pla_stim_pkg SHALL hold defaults for W and CNT_W.
REQ-044 The next-vector logic (up-count or LFSR step) SHALL be one sub-module, pla_stim_next, combinational, taking mode and x and producing next x.

Verification
REQ-045 The bench SHALL cover: mode 1, seed 0xACE1, num_vec 3, out_ready=1 -> x = 0xACE1, 0x59C3, 0xB387 on consecutive cycles, then done pulse one cycle after the last transfer.
REQ-046 The bench SHALL cover: mode 0, seed 0xFFFE, num_vec 4 -> x = 0xFFFE, 0xFFFF, 0x0000, 0x0001; busy high for 5 cycles.
REQ-047 The bench SHALL cover: mode 1, seed 0x0000, num_vec 2 -> x = 0x0001, 0x0002.
REQ-048 The bench SHALL cover: num_vec 0 -> out_valid never asserts; done pulses the cycle after start.
REQ-049 The bench SHALL cover: mode 0, seed 0x0010, num_vec 2, out_ready low 3 cycles -> x holds 0x0010 while stalled, then 0x0011, with exactly 2 transfers.
REQ-050 The bench SHALL cover: rst_n low mid-RUN (and, with PLA_STIM_ABORT_EN, abort mid-RUN) -> out_valid 0 next cycle, no done pulse, and the next start restarts from the new seed.
